// File: rtl/dbus_multi_arbiter_pkg.sv
// Shared types for the multi-port data-bus arbiter.
//   dbus_req_t  : upstream/downstream request (valid, addr, strobe, write data)
//   dbus_resp_t : response (addr_ok, data_ok, read data)
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
//   wrap_next() : index + 1 with modulo wrap, used for the write round-robin pointer
package dbus_multi_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } dbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int wrap_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/dbus_multi_arbiter_rr_picker.sv
// Round-robin picker.
//   req   : request vector
//   start : index searched first; the search wraps modulo N
//   mask  : requesters already taken by an earlier slot (excluded)
//   grant : one-hot grant (all zero when nothing eligible)
//   idx   : binary index of the granted requester
//   any   : a requester was granted
// A start of zero gives plain lowest-index-first priority.
module rr_picker #(
    parameter int  N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        int cand;
        cand  = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(start) + k) % N;
            if (!any && req[cand] && !mask[cand]) begin
                grant[cand] = 1'b1;
                idx         = PW'(cand);
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dbus_multi_arbiter.sv
// Data-bus arbiter mapping NUM_RD read and NUM_WR write requesters onto
// NUM_MEM downstream memory slots.
//   clk, reset : clock and synchronous active-high reset
//   rreq/wreq  : upstream read/write requests (valid held until data_ok)
//   dresp      : per-slot downstream responses
//   dreq       : per-slot downstream requests
//   rresp/wresp: upstream responses, routed through the slot grant map
// Reads fill slots first (lowest index first); writes take the remaining
// slots round-robin from wr_ptr. In IDLE the selection is issued in the same
// cycle; if any slot is still outstanding the grant map is frozen (BUSY) until
// every slot has returned data_ok.
module dbus_multi_arbiter
    import dbus_multi_arbiter_pkg::*;
#(
    parameter int  NUM_RD  = 2,
    parameter int  NUM_WR  = 2,
    parameter int  NUM_MEM = 2,
    localparam int IDX_W   = $clog2(NUM_RD + NUM_WR)
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  rreq  [NUM_RD],
    input  dbus_req_t  wreq  [NUM_WR],
    input  dbus_resp_t dresp [NUM_MEM],
    output dbus_req_t  dreq  [NUM_MEM],
    output dbus_resp_t rresp [NUM_RD],
    output dbus_resp_t wresp [NUM_WR]
);

    localparam int RP_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int WP_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    // Registered state
    arb_state_t         state_reg, state_next;
    logic [IDX_W-1:0]   slot_sel_reg  [NUM_MEM];
    logic [IDX_W-1:0]   slot_sel_next [NUM_MEM];
    logic [NUM_MEM-1:0] slot_pend_reg, slot_pend_next;
    dbus_req_t          saved_req_reg  [NUM_MEM];
    dbus_req_t          saved_req_next [NUM_MEM];
    logic [WP_W-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [WP_W-1:0]    last_wr_reg, last_wr_next;
    logic               has_wr_reg, has_wr_next;

    // IDLE-time selection
    logic [NUM_RD-1:0]  rd_valid;
    logic [NUM_WR-1:0]  wr_valid;
    logic [NUM_RD-1:0]  rd_mask [NUM_MEM];
    logic [NUM_WR-1:0]  wr_mask [NUM_MEM];
    logic [NUM_RD-1:0]  rd_take [NUM_MEM];
    logic [NUM_WR-1:0]  wr_take [NUM_MEM];
    logic [IDX_W-1:0]   sel_idx [NUM_MEM];
    logic [WP_W-1:0]    sel_wr_idx [NUM_MEM];
    dbus_req_t          sel_req [NUM_MEM];
    logic [NUM_MEM-1:0] sel_used;
    logic [NUM_MEM-1:0] sel_is_wr;
    logic [WP_W-1:0]    sel_last_wr;
    logic               sel_any_wr;

    // Current view of the grant map (live selection in IDLE, frozen in BUSY)
    logic [NUM_MEM-1:0] ok_vec;
    logic [NUM_MEM-1:0] cur_act;
    logic [NUM_MEM-1:0] slot_fin;
    logic [IDX_W-1:0]   cur_sel [NUM_MEM];

    genvar gi;

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_valid
            assign rd_valid[gi] = rreq[gi].valid;
        end
        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_valid
            assign wr_valid[gi] = wreq[gi].valid;
        end
        for (gi = 0; gi < NUM_MEM; gi++) begin : g_ok
            assign ok_vec[gi] = dresp[gi].data_ok;
        end
    endgenerate

    // One read picker and one write picker per slot. Each slot excludes the
    // requesters taken by lower slots, so no requester lands in two slots.
    // Write pickers all share the start pointer, so successive slots follow
    // the round-robin order and the highest write slot holds the last write.
    generate
        for (gi = 0; gi < NUM_MEM; gi++) begin : g_slot
            logic [NUM_RD-1:0] rd_grant;
            logic [RP_W-1:0]   rd_idx;
            logic              rd_any;
            logic [NUM_WR-1:0] wr_grant;
            logic [WP_W-1:0]   wr_idx;
            logic              wr_any;

            if (gi == 0) begin : g_first
                assign rd_mask[gi] = '0;
                assign wr_mask[gi] = '0;
            end else begin : g_chain
                assign rd_mask[gi] = rd_mask[gi-1] | rd_take[gi-1];
                assign wr_mask[gi] = wr_mask[gi-1] | wr_take[gi-1];
            end

            rr_picker #(.N(NUM_RD)) u_rd_pick (
                .req   (rd_valid),
                .start ('0),
                .mask  (rd_mask[gi]),
                .grant (rd_grant),
                .idx   (rd_idx),
                .any   (rd_any)
            );

            rr_picker #(.N(NUM_WR)) u_wr_pick (
                .req   (wr_valid),
                .start (wr_ptr_reg),
                .mask  (wr_mask[gi]),
                .grant (wr_grant),
                .idx   (wr_idx),
                .any   (wr_any)
            );

            assign rd_take[gi]    = rd_any ? rd_grant : '0;
            assign wr_take[gi]    = (!rd_any && wr_any) ? wr_grant : '0;
            assign sel_used[gi]   = rd_any | wr_any;
            assign sel_is_wr[gi]  = !rd_any && wr_any;
            assign sel_wr_idx[gi] = wr_idx;
            assign sel_idx[gi]    = rd_any ? IDX_W'(rd_idx)
                                           : IDX_W'(NUM_RD + int'(wr_idx));

            always_comb begin
                sel_req[gi] = '0;
                if (rd_any) begin
                    sel_req[gi] = rreq[rd_idx];
                end else if (wr_any) begin
                    sel_req[gi] = wreq[wr_idx];
                end
            end
        end
    endgenerate

    always_comb begin
        sel_last_wr = '0;
        sel_any_wr  = 1'b0;
        for (int s = 0; s < NUM_MEM; s++) begin
            if (sel_is_wr[s]) begin
                sel_last_wr = sel_wr_idx[s];
                sel_any_wr  = 1'b1;
            end
        end
    end

    // Grant map and downstream requests. Reset suppresses every slot.
    always_comb begin
        for (int s = 0; s < NUM_MEM; s++) begin
            cur_act[s] = 1'b0;
            cur_sel[s] = '0;
            dreq[s]    = '0;
            if (!reset) begin
                if (state_reg == BUSY) begin
                    cur_act[s] = slot_pend_reg[s];
                    cur_sel[s] = slot_sel_reg[s];
                    if (slot_pend_reg[s]) begin
                        dreq[s] = saved_req_reg[s];
                    end
                end else begin
                    cur_act[s] = sel_used[s];
                    cur_sel[s] = sel_idx[s];
                    dreq[s]    = sel_req[s];
                end
            end
            slot_fin[s] = cur_act[s] && ok_vec[s];
        end
    end

    // Upstream responses: a requester completes when its slot returns
    // data_ok; an idle requester always reports data_ok.
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rresp[r]         = '0;
            rresp[r].addr_ok = 1'b1;
            rresp[r].data_ok = !rreq[r].valid;
            for (int s = 0; s < NUM_MEM; s++) begin
                if (slot_fin[s] && (cur_sel[s] == IDX_W'(r))) begin
                    rresp[r].data_ok = 1'b1;
                    rresp[r].data    = dresp[s].data;
                end
            end
        end
        for (int w = 0; w < NUM_WR; w++) begin
            wresp[w]         = '0;
            wresp[w].addr_ok = 1'b1;
            wresp[w].data_ok = !wreq[w].valid;
            for (int s = 0; s < NUM_MEM; s++) begin
                if (slot_fin[s] && (cur_sel[s] == IDX_W'(NUM_RD + w))) begin
                    wresp[w].data_ok = 1'b1;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        logic [NUM_MEM-1:0] pend_left;
        state_next     = state_reg;
        slot_sel_next  = slot_sel_reg;
        slot_pend_next = slot_pend_reg;
        saved_req_next = saved_req_reg;
        wr_ptr_next    = wr_ptr_reg;
        last_wr_next   = last_wr_reg;
        has_wr_next    = has_wr_reg;
        pend_left      = '0;

        case (state_reg)
            IDLE: begin
                pend_left = sel_used & ~ok_vec;
                if (pend_left != '0) begin
                    state_next     = BUSY;
                    slot_sel_next  = sel_idx;
                    saved_req_next = sel_req;
                    slot_pend_next = pend_left;
                    last_wr_next   = sel_last_wr;
                    has_wr_next    = sel_any_wr;
                end else if (sel_any_wr) begin
                    // zero-wait completion: advance past the last write now
                    wr_ptr_next = WP_W'(wrap_next(int'(sel_last_wr), NUM_WR));
                end
            end
            BUSY: begin
                pend_left      = slot_pend_reg & ~ok_vec;
                slot_pend_next = pend_left;
                if (pend_left == '0) begin
                    state_next  = IDLE;
                    has_wr_next = 1'b0;
                    if (has_wr_reg) begin
                        wr_ptr_next = WP_W'(wrap_next(int'(last_wr_reg), NUM_WR));
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            slot_pend_reg <= '0;
            wr_ptr_reg    <= '0;
            last_wr_reg   <= '0;
            has_wr_reg    <= 1'b0;
            for (int s = 0; s < NUM_MEM; s++) begin
                slot_sel_reg[s]  <= '0;
                saved_req_reg[s] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            slot_pend_reg <= slot_pend_next;
            wr_ptr_reg    <= wr_ptr_next;
            last_wr_reg   <= last_wr_next;
            has_wr_reg    <= has_wr_next;
            for (int s = 0; s < NUM_MEM; s++) begin
                slot_sel_reg[s]  <= slot_sel_next[s];
                saved_req_reg[s] <= saved_req_next[s];
            end
        end
    end

endmodule

// File: tb/tb_dbus_multi_arbiter.sv
// Bench for dbus_multi_arbiter: main instance (2 rd / 2 wr / 2 slots) checked
// every cycle against a list-based model, plus directed checks on a
// 3 rd / 1 wr / 2 slot instance and a 1 rd / 2 wr / 1 slot instance.
module tb_dbus_multi_arbiter;
    import dbus_multi_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int NW = 2;
    localparam int NM = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    dbus_req_t  rreq [NR];
    dbus_req_t  wreq [NW];
    dbus_resp_t dresp [NM];
    dbus_req_t  dreq [NM];
    dbus_resp_t rresp [NR];
    dbus_resp_t wresp [NW];

    dbus_req_t  b_rreq [3];
    dbus_req_t  b_wreq [1];
    dbus_resp_t b_dresp [2];
    dbus_req_t  b_dreq [2];
    dbus_resp_t b_rresp [3];
    dbus_resp_t b_wresp [1];

    dbus_req_t  c_rreq [1];
    dbus_req_t  c_wreq [2];
    dbus_resp_t c_dresp [1];
    dbus_req_t  c_dreq [1];
    dbus_resp_t c_rresp [1];
    dbus_resp_t c_wresp [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dbus_multi_arbiter #(.NUM_RD(NR), .NUM_WR(NW), .NUM_MEM(NM)) dut (
        .clk(clk), .reset(reset), .rreq(rreq), .wreq(wreq), .dresp(dresp),
        .dreq(dreq), .rresp(rresp), .wresp(wresp)
    );

    dbus_multi_arbiter #(.NUM_RD(3), .NUM_WR(1), .NUM_MEM(2)) dut_b (
        .clk(clk), .reset(reset), .rreq(b_rreq), .wreq(b_wreq), .dresp(b_dresp),
        .dreq(b_dreq), .rresp(b_rresp), .wresp(b_wresp)
    );

    dbus_multi_arbiter #(.NUM_RD(1), .NUM_WR(2), .NUM_MEM(1)) dut_c (
        .clk(clk), .reset(reset), .rreq(c_rreq), .wreq(c_wreq), .dresp(c_dresp),
        .dreq(c_dreq), .rresp(c_rresp), .wresp(c_wresp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Requesters present a known address while valid and garbage otherwise,
    // so a slot that follows the live request instead of its saved copy shows.
    task automatic set_rd(input int i, input bit v);
        rreq[i].valid  = v;
        rreq[i].addr   = v ? (32'h1000 + 32'(i)) : 32'hDEAD_0000;
        rreq[i].strobe = '0;
        rreq[i].data   = '0;
    endtask

    task automatic set_wr(input int j, input bit v);
        wreq[j].valid  = v;
        wreq[j].addr   = v ? (32'h2000 + 32'(j)) : 32'hDEAD_0000;
        wreq[j].strobe = 4'hF;
        wreq[j].data   = 32'h5A00 + 32'(j);
    endtask

    task automatic set_ok(input int s, input bit ok, input logic [31:0] d);
        dresp[s].addr_ok = 1'b1;
        dresp[s].data_ok = ok;
        dresp[s].data    = d;
    endtask

    task automatic clear_main();
        for (int i = 0; i < NR; i++) set_rd(i, 1'b0);
        for (int j = 0; j < NW; j++) set_wr(j, 1'b0);
        for (int s = 0; s < NM; s++) set_ok(s, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model of the main instance ----------------
    function automatic logic [31:0] req_addr(input int r);
        return (r < NR) ? (32'h1000 + 32'(r)) : (32'h2000 + 32'(r - NR));
    endfunction

    int  m_busy = 0;
    int  m_wr_ptr = 0;
    int  m_last_wr = -1;
    int  m_grant [NM];
    bit  m_pend [NM];
    int  n_busy, n_wr_ptr, n_last_wr;
    int  n_grant [NM];
    bit  n_pend [NM];
    int  g [NM];
    bit  act [NM];
    int  order [$];

    initial begin
        bit          anyp;
        int          lastw;
        bit          v_r, ok_r, exp_ok, routed;
        logic [31:0] d_r, exp_d;
        for (int s = 0; s < NM; s++) begin
            m_grant[s] = -1;
            m_pend[s]  = 1'b0;
        end
        forever begin
            @(negedge clk);
            n_busy = m_busy; n_wr_ptr = m_wr_ptr; n_last_wr = m_last_wr;
            n_grant = m_grant; n_pend = m_pend;
            if (reset) begin
                for (int s = 0; s < NM; s++) begin
                    g[s] = -1; act[s] = 1'b0; n_pend[s] = 1'b0;
                end
                n_busy = 0; n_wr_ptr = 0; n_last_wr = -1;
            end else if (m_busy == 0) begin
                // reads ascending, then writes in round-robin order from wr_ptr
                order.delete();
                for (int i = 0; i < NR; i++) if (rreq[i].valid) order.push_back(i);
                for (int k = 0; k < NW; k++)
                    if (wreq[(m_wr_ptr + k) % NW].valid) order.push_back(NR + (m_wr_ptr + k) % NW);
                lastw = -1; anyp = 1'b0;
                for (int s = 0; s < NM; s++) begin
                    g[s]   = (s < order.size()) ? order[s] : -1;
                    act[s] = (g[s] >= 0);
                    if (act[s] && g[s] >= NR) lastw = g[s] - NR;
                    if (act[s] && !dresp[s].data_ok) anyp = 1'b1;
                end
                if (anyp) begin
                    n_busy = 1; n_last_wr = lastw;
                    for (int s = 0; s < NM; s++) begin
                        n_grant[s] = g[s];
                        n_pend[s]  = act[s] && !dresp[s].data_ok;
                    end
                end else if (lastw >= 0) begin
                    n_wr_ptr = (lastw + 1) % NW;
                end
            end else begin
                anyp = 1'b0;
                for (int s = 0; s < NM; s++) begin
                    g[s] = m_grant[s];
                    act[s] = m_pend[s];
                    n_pend[s] = m_pend[s] && !dresp[s].data_ok;
                    if (n_pend[s]) anyp = 1'b1;
                end
                if (!anyp) begin
                    n_busy = 0;
                    if (m_last_wr >= 0) n_wr_ptr = (m_last_wr + 1) % NW;
                end
            end

            for (int s = 0; s < NM; s++) begin
                chk($sformatf("model dreq%0d.valid", s), 32'(dreq[s].valid), 32'(act[s]));
                if (act[s]) chk($sformatf("model dreq%0d.addr", s), dreq[s].addr, req_addr(g[s]));
            end
            for (int r = 0; r < NR + NW; r++) begin
                v_r    = (r < NR) ? rreq[r].valid : wreq[r - NR].valid;
                ok_r   = (r < NR) ? rresp[r].data_ok : wresp[r - NR].data_ok;
                d_r    = (r < NR) ? rresp[r].data : 32'h0;
                exp_ok = !v_r; routed = 1'b0; exp_d = 32'h0;
                for (int s = 0; s < NM; s++) begin
                    if (act[s] && g[s] == r && dresp[s].data_ok) begin
                        exp_ok = 1'b1; routed = 1'b1; exp_d = dresp[s].data;
                    end
                end
                chk($sformatf("model resp%0d.data_ok", r), 32'(ok_r), 32'(exp_ok));
                chk($sformatf("model resp%0d.addr_ok", r),
                    32'((r < NR) ? rresp[r].addr_ok : wresp[r - NR].addr_ok), 32'd1);
                if (routed && r < NR) chk($sformatf("model rresp%0d.data", r), d_r, exp_d);
                if (routed && v_r) $display("txn t=%0t requester %0d %s done data=%h",
                                            $time, r, (r < NR) ? "rd" : "wr", exp_d);
            end

            @(posedge clk);
            m_busy = n_busy; m_wr_ptr = n_wr_ptr; m_last_wr = n_last_wr;
            m_grant = n_grant; m_pend = n_pend;
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        clear_main();
        for (int i = 0; i < 3; i++) begin
            b_rreq[i] = '0; b_rreq[i].addr = 32'h1000 + 32'(i);
        end
        b_wreq[0] = '0; b_wreq[0].addr = 32'h2000;
        for (int s = 0; s < 2; s++) begin
            b_dresp[s] = '0; b_dresp[s].addr_ok = 1'b1;
        end
        c_rreq[0] = '0; c_rreq[0].addr = 32'h1000;
        for (int j = 0; j < 2; j++) begin
            c_wreq[j] = '0; c_wreq[j].addr = 32'h2000 + 32'(j);
        end
        c_dresp[0] = '0; c_dresp[0].addr_ok = 1'b1;

        // reset: no downstream request, no completion even with a valid reader
        reset = 1'b1;
        set_rd(0, 1'b1);
        #3;
        chk("reset dreq0.valid", 32'(dreq[0].valid), 32'd0);
        chk("reset rresp0.data_ok", 32'(rresp[0].data_ok), 32'd0);
        tick(); tick();
        reset = 1'b0;
        set_rd(0, 1'b0);
        tick();

        // both reads, zero-wait completion
        set_rd(0, 1'b1); set_rd(1, 1'b1);
        set_ok(0, 1'b1, 32'hAAAA_0000); set_ok(1, 1'b1, 32'hBBBB_1111);
        #3;
        chk("zw rresp0.data_ok", 32'(rresp[0].data_ok), 32'd1);
        chk("zw rresp1.data_ok", 32'(rresp[1].data_ok), 32'd1);
        chk("zw rresp0.data", rresp[0].data, 32'hAAAA_0000);
        chk("zw rresp1.data", rresp[1].data, 32'hBBBB_1111);
        chk("zw dreq1.addr", dreq[1].addr, 32'h0000_1001);
        tick();
        set_rd(1, 1'b0);
        #3;
        chk("zw still idle dreq0.valid", 32'(dreq[0].valid), 32'd1);
        chk("zw still idle rresp0.data_ok", 32'(rresp[0].data_ok), 32'd1);
        tick();
        clear_main();
        tick();

        // read1 + write0 + write1, slot 1 held for three cycles
        set_rd(1, 1'b1); set_wr(0, 1'b1); set_wr(1, 1'b1);
        set_ok(0, 1'b1, 32'h1111_0000); set_ok(1, 1'b0, 32'h2222_0000);
        #3;
        chk("mix dreq0.addr", dreq[0].addr, 32'h0000_1001);
        chk("mix dreq1.addr", dreq[1].addr, 32'h0000_2000);
        chk("mix rresp1.data_ok", 32'(rresp[1].data_ok), 32'd1);
        chk("mix rresp1.data", rresp[1].data, 32'h1111_0000);
        chk("mix wresp0.data_ok c0", 32'(wresp[0].data_ok), 32'd0);
        tick();
        set_rd(1, 1'b0);
        #3;
        chk("mix busy dreq0.valid", 32'(dreq[0].valid), 32'd0);
        chk("mix busy dreq1.addr", dreq[1].addr, 32'h0000_2000);
        chk("mix busy wresp1.data_ok", 32'(wresp[1].data_ok), 32'd0);
        tick();
        #3;
        chk("mix wresp0.data_ok c2", 32'(wresp[0].data_ok), 32'd0);
        tick();
        set_ok(1, 1'b1, 32'h3333_0000);
        #3;
        chk("mix wresp0.data_ok c3", 32'(wresp[0].data_ok), 32'd1);
        tick();
        set_wr(0, 1'b0);
        #3;
        chk("mix next grant write1", dreq[0].addr, 32'h0000_2001);
        chk("mix next dreq1.valid", 32'(dreq[1].valid), 32'd0);
        chk("mix wresp1.data_ok", 32'(wresp[1].data_ok), 32'd1);
        tick();
        clear_main();
        tick();

        // slot 0 completes at cycle 2, slot 1 at cycle 5; write0 waits
        set_rd(0, 1'b1); set_rd(1, 1'b1); set_wr(0, 1'b1);
        #3;
        chk("stag dreq0.addr", dreq[0].addr, 32'h0000_1000);
        chk("stag dreq1.addr", dreq[1].addr, 32'h0000_1001);
        tick();
        for (int k = 1; k <= 5; k++) begin
            set_ok(0, (k == 2), 32'h0C00_0000 + 32'(k));
            set_ok(1, (k == 5), 32'h0D00_0000 + 32'(k));
            if (k == 3) begin
                set_rd(0, 1'b0);
                set_rd(1, 1'b0);   // read1 drops early; its saved request stays
            end
            #3;
            chk($sformatf("stag dreq0.valid c%0d", k), 32'(dreq[0].valid), 32'(k <= 2));
            chk($sformatf("stag dreq1.addr c%0d", k), dreq[1].addr, 32'h0000_1001);
            chk($sformatf("stag wresp0 wait c%0d", k), 32'(wresp[0].data_ok), 32'd0);
            tick();
        end
        set_ok(0, 1'b1, 32'h0E00_0000); set_ok(1, 1'b1, 32'h0F00_0000);
        #3;
        chk("stag new grant addr", dreq[0].addr, 32'h0000_2000);
        chk("stag new grant data_ok", 32'(wresp[0].data_ok), 32'd1);
        tick();
        clear_main();
        tick();

        // reset in BUSY discards outstanding slots and resets wr_ptr
        set_rd(0, 1'b1); set_wr(0, 1'b1);
        #3;
        chk("rstb dreq1.addr", dreq[1].addr, 32'h0000_2000);
        tick();
        tick();
        reset = 1'b1;
        set_ok(0, 1'b1, 32'h7777_0000); set_ok(1, 1'b1, 32'h8888_0000);
        #3;
        chk("rstb dreq0.valid", 32'(dreq[0].valid), 32'd0);
        chk("rstb dreq1.valid", 32'(dreq[1].valid), 32'd0);
        chk("rstb rresp0.data_ok", 32'(rresp[0].data_ok), 32'd0);
        chk("rstb wresp0.data_ok", 32'(wresp[0].data_ok), 32'd0);
        tick();
        reset = 1'b0;
        set_rd(0, 1'b0); set_wr(0, 1'b1); set_wr(1, 1'b1);
        set_ok(0, 1'b0, 32'h0); set_ok(1, 1'b0, 32'h0);
        #3;
        chk("rstb wr_ptr 0 slot0", dreq[0].addr, 32'h0000_2000);
        chk("rstb slot1", dreq[1].addr, 32'h0000_2001);
        chk("rstb no data_ok", 32'(wresp[0].data_ok), 32'd0);
        tick();
        set_ok(0, 1'b1, 32'h0); set_ok(1, 1'b1, 32'h0);
        tick();
        clear_main();
        tick();

        // 3 rd / 1 wr / 2 slots: reads 0,1 first, then read2 with write0
        for (int i = 0; i < 3; i++) b_rreq[i].valid = 1'b1;
        b_wreq[0].valid = 1'b1;
        b_dresp[0].data_ok = 1'b1; b_dresp[1].data_ok = 1'b1;
        b_dresp[0].data = 32'hB0; b_dresp[1].data = 32'hB1;
        #3;
        chk("b dreq0.addr", b_dreq[0].addr, 32'h0000_1000);
        chk("b dreq1.addr", b_dreq[1].addr, 32'h0000_1001);
        chk("b rresp1.data", b_rresp[1].data, 32'h0000_00B1);
        chk("b rresp2 waits", 32'(b_rresp[2].data_ok), 32'd0);
        chk("b wresp0 waits", 32'(b_wresp[0].data_ok), 32'd0);
        tick();
        b_rreq[0].valid = 1'b0; b_rreq[1].valid = 1'b0;
        #3;
        chk("b2 dreq0.addr", b_dreq[0].addr, 32'h0000_1002);
        chk("b2 dreq1.addr", b_dreq[1].addr, 32'h0000_2000);
        chk("b2 rresp2.data_ok", 32'(b_rresp[2].data_ok), 32'd1);
        chk("b2 wresp0.data_ok", 32'(b_wresp[0].data_ok), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) b_rreq[i].valid = 1'b0;
        b_wreq[0].valid = 1'b0;
        tick();

        // 1 rd / 2 wr / 1 slot: writes alternate 0,1,0,1
        c_wreq[0].valid = 1'b1; c_wreq[1].valid = 1'b1;
        c_dresp[0].data_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk($sformatf("c alt addr t%0d", k), c_dreq[0].addr, 32'h2000 + 32'(k % 2));
            chk($sformatf("c alt data_ok t%0d", k), 32'(c_wresp[k % 2].data_ok), 32'd1);
            chk($sformatf("c alt other waits t%0d", k), 32'(c_wresp[(k + 1) % 2].data_ok), 32'd0);
            tick();
        end
        c_wreq[0].valid = 1'b0; c_wreq[1].valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
